// File: rtl/btn_pos_controller.sv
// Button-driven box centre position for the VGA box renderer.
// Debounces four buttons and steps x/y with auto-repeat and clamping.
module btn_pos_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TICK_DIV        = 416667,
  parameter int REPEAT_DELAY    = 20,
  parameter int STEP            = 4,
  parameter int SIZE            = 32,
  parameter int INIT_X          = 320,
  parameter int INIT_Y          = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       moving
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TKW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RPW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;

  localparam logic signed [10:0] LO  = 11'(SIZE / 2);
  localparam logic signed [10:0] HIX = 11'(640 - SIZE / 2);
  localparam logic signed [10:0] HIY = 11'(480 - SIZE / 2);
  localparam logic signed [10:0] STP = 11'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RPT
  } axis_st_e;

  logic [3:0]     s1_q, s2_q;
  logic [3:0]     db_q, db_d;
  logic [DBW-1:0] cnt_q [4];
  logic [DBW-1:0] cnt_d [4];

  logic [TKW-1:0] tck_q, tck_d;
  logic           tick;

  axis_st_e       st_q   [2];
  axis_st_e       st_d   [2];
  logic [1:0]     ldir_q [2];
  logic [1:0]     ldir_d [2];
  logic [RPW-1:0] rep_q  [2];
  logic [RPW-1:0] rep_d  [2];
  logic [1:0]     dir    [2];
  logic           step   [2];

  logic signed [10:0] pos  [2];
  logic signed [10:0] nraw [2];
  logic signed [10:0] hi   [2];
  logic [9:0]         npos [2];

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       mv_q, mv_d;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DBW'(1);
        end
      end
    end
  end

  assign tick  = (tck_q == TKW'(TICK_DIV - 1));
  assign tck_d = tick ? '0 : tck_q + TKW'(1);

  // dir encoding: 2'b01 = +1, 2'b11 = -1, 2'b00 = none
  assign dir[0] = {db_q[1] & ~db_q[0], db_q[1] ^ db_q[0]};
  assign dir[1] = {db_q[3] & ~db_q[2], db_q[3] ^ db_q[2]};

  always_comb begin
    for (int a = 0; a < 2; a++) begin
      st_d[a]   = st_q[a];
      ldir_d[a] = ldir_q[a];
      rep_d[a]  = rep_q[a];
      step[a]   = 1'b0;
      unique case (st_q[a])
        IDLE: begin
          if (dir[a] != 2'b00) begin
            step[a]   = 1'b1;
            ldir_d[a] = dir[a];
            rep_d[a]  = '0;
            st_d[a]   = DELAY;
          end
        end
        DELAY, RPT: begin
          if (dir[a] == 2'b00) begin
            st_d[a] = IDLE;
          end else if (dir[a] != ldir_q[a]) begin
            step[a]   = 1'b1;
            ldir_d[a] = dir[a];
            rep_d[a]  = '0;
            st_d[a]   = DELAY;
          end else if (tick) begin
            if (st_q[a] == RPT) begin
              step[a] = 1'b1;
            end else if (rep_q[a] == RPW'(REPEAT_DELAY - 1)) begin
              rep_d[a] = '0;
              st_d[a]  = RPT;
            end else begin
              rep_d[a] = rep_q[a] + RPW'(1);
            end
          end
        end
        default: st_d[a] = IDLE;
      endcase
    end
  end

  assign pos[0] = signed'({1'b0, x_q});
  assign pos[1] = signed'({1'b0, y_q});
  assign hi[0]  = HIX;
  assign hi[1]  = HIY;

  // Clamp keeps the whole box on screen; partial steps onto a bound are allowed.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      nraw[a] = ldir_d[a][1] ? pos[a] - STP : pos[a] + STP;
      npos[a] = pos[a][9:0];
      if (step[a]) begin
        if (nraw[a] < LO) begin
          npos[a] = LO[9:0];
        end else if (nraw[a] > hi[a]) begin
          npos[a] = hi[a][9:0];
        end else begin
          npos[a] = nraw[a][9:0];
        end
      end
    end
  end

  assign x_d  = npos[0];
  assign y_d  = npos[1];
  assign mv_d = (x_d != x_q) || (y_d != y_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      db_q  <= '0;
      tck_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      for (int a = 0; a < 2; a++) begin
        st_q[a]   <= IDLE;
        ldir_q[a] <= '0;
        rep_q[a]  <= '0;
      end
      x_q  <= 10'(INIT_X);
      y_q  <= 10'(INIT_Y);
      mv_q <= 1'b0;
    end else begin
      s1_q  <= btn;
      s2_q  <= s1_q;
      db_q  <= db_d;
      tck_q <= tck_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      for (int a = 0; a < 2; a++) begin
        st_q[a]   <= st_d[a];
        ldir_q[a] <= ldir_d[a];
        rep_q[a]  <= rep_d[a];
      end
      x_q  <= x_d;
      y_q  <= y_d;
      mv_q <= mv_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign moving = mv_q;

endmodule

// File: tb/tb_btn_pos_controller.sv
// Directed bench for btn_pos_controller with short debounce/tick periods.
// A second instance starts next to the bounds to exercise clamping.
module tb_btn_pos_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn, btn2;
  logic [9:0] x, y, x2, y2;
  logic       moving, mv2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  btn_pos_controller #(
    .DEBOUNCE_CYCLES(4), .TICK_DIV(8), .REPEAT_DELAY(3), .STEP(4)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .x(x), .y(y), .moving(moving)
  );

  btn_pos_controller #(
    .DEBOUNCE_CYCLES(4), .TICK_DIV(8), .REPEAT_DELAY(3), .STEP(4),
    .INIT_X(18), .INIT_Y(462)
  ) dut2 (
    .clk(clk), .rst(rst), .btn(btn2),
    .x(x2), .y(y2), .moving(mv2)
  );

  typedef struct {
    logic [3:0] b;
    int         hold;
    int         ex;
    int         ey;
    int         mv;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic run_cnt(input int n, output int m);
    m = 0;
    repeat (n) begin
      @(negedge clk);
      if (moving) m++;
    end
  endtask

  task automatic run2(input int n, output int m);
    m = 0;
    repeat (n) begin
      @(negedge clk);
      if (mv2) m++;
    end
  endtask

  task automatic wait_move(input int maxc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!moving && n < maxc);
    if (!moving) begin
      total++;
      bad++;
      $display("FAIL wait_move: got no moving pulse expected one within %0d", maxc);
    end
  endtask

  initial begin
    int m, m2, n, k;

    tbl[0] = '{4'b0001, 3,  320, 240, 0};
    tbl[1] = '{4'b0001, 20, 324, 240, 1};
    tbl[2] = '{4'b0010, 12, 320, 240, 1};
    tbl[3] = '{4'b0100, 12, 320, 244, 1};
    tbl[4] = '{4'b1000, 12, 320, 240, 1};
    tbl[5] = '{4'b0101, 12, 324, 244, 1};
    tbl[6] = '{4'b0011, 12, 324, 244, 0};
    tbl[7] = '{4'b1100, 12, 324, 244, 0};
    tbl[8] = '{4'b1010, 12, 320, 240, 1};

    rst  = 1'b0;
    btn  = 4'b1111;
    btn2 = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rst_x", int'(x), 320);
    chk("rst_y", int'(y), 240);
    chk("rst_mv", int'(moving), 0);
    chk("rst_x2", int'(x2), 18);
    chk("rst_y2", int'(y2), 462);
    rst = 1'b1;
    run_cnt(30, m);
    chk("cancel_mv", m, 0);
    chk("cancel_x", int'(x), 320);
    chk("cancel_y", int'(y), 240);
    btn = 4'b0000;
    run_cnt(14, m);

    for (int i = 0; i < 9; i++) begin
      btn = tbl[i].b;
      run_cnt(tbl[i].hold, m);
      btn = 4'b0000;
      run_cnt(14, m2);
      chk($sformatf("vec%0d_mv", i), m + m2, tbl[i].mv);
      chk($sformatf("vec%0d_x", i), int'(x), tbl[i].ex);
      chk($sformatf("vec%0d_y", i), int'(y), tbl[i].ey);
    end

    btn2 = 4'b0100;
    run2(12, m);
    btn2 = 4'b0000;
    run2(14, m2);
    chk("clampy_mv", m + m2, 1);
    chk("clampy_y", int'(y2), 464);
    btn2 = 4'b0010;
    run2(12, m);
    btn2 = 4'b0000;
    run2(14, m2);
    chk("clampx_mv", m + m2, 1);
    chk("clampx_x", int'(x2), 16);
    btn2 = 4'b0110;
    run2(60, m);
    btn2 = 4'b0000;
    chk("clamp_hold_mv", m, 0);
    chk("clamp_hold_x", int'(x2), 16);
    chk("clamp_hold_y", int'(y2), 464);

    btn = 4'b1000;
    wait_move(12, n);
    chk_rng("rep_first_lat", n, 6, 8);
    chk("rep_y1", int'(y), 236);
    wait_move(40, n);
    chk_rng("rep_delay_gap", n, 25, 32);
    chk("rep_y2", int'(y), 232);
    wait_move(12, n);
    chk("rep_gap3", n, 8);
    chk("rep_y3", int'(y), 228);
    wait_move(12, n);
    chk("rep_gap4", n, 8);
    chk("rep_y4", int'(y), 224);
    btn = 4'b0000;
    run_cnt(40, m);
    chk("rep_stop_mv", m, 0);
    chk("rep_stop_y", int'(y), 224);

    btn = 4'b0010;
    k = 0;
    while (x != 10'd20 && k < 100) begin
      wait_move(40, n);
      k++;
    end
    btn = 4'b0000;
    chk("walk_x", int'(x), 20);
    run_cnt(20, m);
    chk("walk_stop_mv", m, 0);
    btn = 4'b0010;
    wait_move(12, n);
    chk("bound_x", int'(x), 16);
    run_cnt(80, m);
    chk("bound_hold_mv", m, 0);
    chk("bound_hold_x", int'(x), 16);
    btn = 4'b0000;
    run_cnt(14, m);

    btn = 4'b0001;
    wait_move(12, n);
    chk("chg_x1", int'(x), 20);
    wait_move(40, n);
    chk("chg_x2", int'(x), 24);
    wait_move(12, n);
    chk("chg_gap", n, 8);
    chk("chg_x3", int'(x), 28);
    btn = 4'b0010;
    wait_move(12, n);
    chk_rng("chg_lat", n, 5, 9);
    chk("chg_x4", int'(x), 24);
    wait_move(40, n);
    chk_rng("chg_redelay", n, 25, 32);
    chk("chg_x5", int'(x), 20);
    btn = 4'b0000;
    run_cnt(14, m);
    chk("chg_y", int'(y), 224);

    btn = 4'b0101;
    wait_move(12, n);
    chk("diag_x1", int'(x), 24);
    chk("diag_y1", int'(y), 228);
    wait_move(40, n);
    wait_move(12, n);
    chk("diag_x3", int'(x), 32);
    chk("diag_y3", int'(y), 236);
    #2 rst = 1'b0;
    #1;
    chk("arst_x", int'(x), 320);
    chk("arst_y", int'(y), 240);
    chk("arst_mv", int'(moving), 0);
    @(negedge clk);
    rst = 1'b1;
    wait_move(12, n);
    chk_rng("arst_relat", n, 6, 8);
    chk("arst_x2", int'(x), 324);
    chk("arst_y2", int'(y), 244);
    btn = 4'b0000;
    run_cnt(14, m);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
